led_model: RTL and testbench

LED_MODEL -- requirements
Module: led_model

---
 rtl/led_model_pkg.sv | 19 +
 rtl/led_model_sync.sv | 66 ++++++
 rtl/led_model.sv | 123 ++++++++++++
 tb/tb_led_model.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/led_model_pkg.sv
// led_model_pkg: shared types and constants for the WS2801-style LED model.
// Holds the capture/forward state enum, the colour word width, the bit
// counter width and a helper that turns clock/idle settings into a cycle count.
package led_model_pkg;

  localparam int RGB_W     = 24;
  localparam int BIT_CNT_W = 5;

  typedef enum logic {
    CAPTURE = 1'b0,
    FORWARD = 1'b1
  } state_t;

  // Number of clk cycles of CKI-low idle that constitutes a latch request.
  function automatic int latch_cycles(input int clk_hz, input int latch_us);
    return (clk_hz / 1_000_000) * latch_us;
  endfunction

endpackage

// File: rtl/led_model_sync.sv
// led_model_sync: input conditioning for SDI/CKI plus the CKI rising-edge
// detector.
// Build option LED_MODEL_SYNC_EN: when defined, SDI and CKI each go through a
// two-flop synchronizer; when undefined, through a single sampling flop.
// Both signals always share the same path so their alignment is preserved.
module led_model_sync
  import led_model_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_sdi,
  input  logic i_cki,
  output logic o_sdi,
  output logic o_cki,
  output logic o_cki_rise
);

  logic r_sdi_s;
  logic r_cki_s;
  logic r_cki_prev;

`ifdef LED_MODEL_SYNC_EN
  logic r_sdi_meta;
  logic r_cki_meta;

  // Two-flop synchronizer on both serial inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sdi_meta <= 1'b0;
      r_cki_meta <= 1'b0;
      r_sdi_s    <= 1'b0;
      r_cki_s    <= 1'b0;
    end else begin
      r_sdi_meta <= i_sdi;
      r_cki_meta <= i_cki;
      r_sdi_s    <= r_sdi_meta;
      r_cki_s    <= r_cki_meta;
    end
  end
`else
  // Single sampling flop on both serial inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sdi_s <= 1'b0;
      r_cki_s <= 1'b0;
    end else begin
      r_sdi_s <= i_sdi;
      r_cki_s <= i_cki;
    end
  end
`endif

  // Edge history for the conditioned CKI.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cki_prev <= 1'b0;
    end else begin
      r_cki_prev <= r_cki_s;
    end
  end

  assign o_sdi      = r_sdi_s;
  assign o_cki      = r_cki_s;
  assign o_cki_rise = r_cki_s & ~r_cki_prev;

endmodule

// File: rtl/led_model.sv
// led_model: behavioural model of one WS2801-style RGB LED driver.
// The first 24 bits clocked in on CKI (MSB first) are captured; every later
// bit is forwarded on SDO/CKO to the next device. A CKI-low idle period of
// LATCH_US microseconds latches a complete 24-bit word onto rgb.
// Build option LED_MODEL_SYNC_EN selects a two-flop input synchronizer
// (see led_model_sync); the default is a single sampling flop.
module led_model
  import led_model_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int LATCH_US = 500
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          SDI,
  input  logic          CKI,
  output logic          SDO,
  output logic          CKO,
  output logic [23:0]   rgb,
  output logic          o_dbg_state
);

  localparam int LATCH_CYCLES = latch_cycles(CLK_HZ, LATCH_US);
  localparam int IDLE_W       = $clog2(LATCH_CYCLES + 1);

  logic                 w_sdi_c;
  logic                 w_cki_c;
  logic                 w_cki_rise;
  logic                 w_latch;

  state_t               r_state;
  logic [RGB_W-1:0]     r_shift;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [RGB_W-1:0]     r_rgb;
  logic                 r_sdo;
  logic                 r_cko;
  logic                 r_fwd_armed;
  logic [IDLE_W-1:0]    r_idle;

  led_model_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_sdi      (SDI),
    .i_cki      (CKI),
    .o_sdi      (w_sdi_c),
    .o_cki      (w_cki_c),
    .o_cki_rise (w_cki_rise)
  );

  // Latch fires on the single cycle the idle counter steps onto LATCH_CYCLES;
  // once saturated it no longer matches, so a long idle fires only once.
  assign w_latch = ~w_cki_c && (r_idle == IDLE_W'(LATCH_CYCLES - 1));

  // Idle counter: counts CKI-low cycles, clears on CKI high, saturates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idle <= '0;
    end else if (w_cki_c) begin
      r_idle <= '0;
    end else if (r_idle != IDLE_W'(LATCH_CYCLES)) begin
      r_idle <= r_idle + 1'b1;
    end
  end

  // Capture/forward FSM with shift register, bit counter, colour latch and
  // registered forwarding outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= CAPTURE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_rgb       <= '0;
      r_sdo       <= 1'b0;
      r_cko       <= 1'b0;
      r_fwd_armed <= 1'b0;
    end else if (w_latch) begin
      // Latch wins over any coincident CKI edge; a partial frame is dropped.
      if (r_bit_cnt == BIT_CNT_W'(RGB_W)) begin
        r_rgb <= r_shift;
      end
      r_bit_cnt   <= '0;
      r_state     <= CAPTURE;
      r_sdo       <= 1'b0;
      r_cko       <= 1'b0;
      r_fwd_armed <= 1'b0;
    end else begin
      case (r_state)
        CAPTURE: begin
          r_sdo       <= 1'b0;
          r_cko       <= 1'b0;
          r_fwd_armed <= 1'b0;
          if (w_cki_rise) begin
            r_shift   <= {r_shift[RGB_W-2:0], w_sdi_c};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == BIT_CNT_W'(RGB_W - 1)) begin
              r_state <= FORWARD;
            end
          end
        end
        FORWARD: begin
          // CKI is still high from the 24th bit when FORWARD is entered; CKO
          // stays low until CKI has been seen low, so that bit's clock is
          // never passed on. After that CKO tracks CKI one clk late, exactly
          // like SDO.
          r_sdo <= w_sdi_c;
          r_cko <= w_cki_c & r_fwd_armed;
          if (!w_cki_c) begin
            r_fwd_armed <= 1'b1;
          end
        end
        default: begin
          r_state <= CAPTURE;
        end
      endcase
    end
  end

  assign SDO         = r_sdo;
  assign CKO         = r_cko;
  assign rgb         = r_rgb;
  assign o_dbg_state = (r_state == FORWARD);

endmodule

// File: tb/tb_led_model.sv
// tb_led_model: five-device chain of led_model driven with directed and
// random frames; a bit-list reference model predicts every device's colour
// and the bits that fall off the end of the chain.
module tb_led_model;

  localparam int N     = 5;
  localparam int LATCH = 20;  // 4 MHz * 5 us

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sdi_in = 1'b0;
  logic          cki_in = 1'b0;
  logic [N:0]    w_sdi;
  logic [N:0]    w_cki;
  logic [23:0]   w_rgb [0:N-1];
  logic [N-1:0]  w_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  logic [23:0]   exp_rgb [0:N-1];
  logic          frame_q[$];
  logic [0:0]    exp_q[$];
  logic [0:0]    mon_q[$];
  logic          last_cko_q = 1'b0;

  assign w_sdi[0] = sdi_in;
  assign w_cki[0] = cki_in;

  // clock/reset
  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_chain
    led_model #(.CLK_HZ(4_000_000), .LATCH_US(5)) u_led (
      .clk         (clk),
      .rst_n       (rst_n),
      .SDI         (w_sdi[g]),
      .CKI         (w_cki[g]),
      .SDO         (w_sdi[g+1]),
      .CKO         (w_cki[g+1]),
      .rgb         (w_rgb[g]),
      .o_dbg_state (w_dbg[g])
    );
  end

  // Collect the data bits leaving the last device on its CKO rising edges.
  always @(negedge clk) begin
    if (w_cki[N] && !last_cko_q) mon_q.push_back(w_sdi[N]);
    last_cko_q = w_cki[N];
  end

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic send_bit(input logic b, input bit rnd);
    int lo, hi;
    lo = rnd ? $urandom_range(2, 4) : 4;
    hi = rnd ? $urandom_range(2, 4) : 4;
    sdi_in = b;
    cki_in = 1'b0;
    repeat (lo) @(posedge clk);
    #1 cki_in = 1'b1;
    repeat (hi) @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [23:0] w, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) frame_q.push_back(w[i]);
  endtask

  task automatic send_frame(input bit rnd);
    mon_q.delete();
    foreach (frame_q[i]) send_bit(frame_q[i], rnd);
  endtask

  // Reference model: device k owns bits [24k, 24k+24) of the frame since the
  // last latch; it updates only if all 24 arrived. Bits past 24*N exit the chain.
  task automatic model_latch();
    exp_q.delete();
    for (int k = 0; k < N; k++) begin
      if (frame_q.size() >= 24 * (k + 1)) begin
        logic [23:0] w;
        w = '0;
        for (int j = 0; j < 24; j++) w = {w[22:0], frame_q[24 * k + j]};
        exp_rgb[k] = w;
      end
    end
    for (int j = 24 * N; j < frame_q.size(); j++) exp_q.push_back(frame_q[j]);
    frame_q.delete();
  endtask

  task automatic latch_and_check(input string tag);
    sdi_in = 1'b0;
    cki_in = 1'b0;
    repeat (LATCH + 40) @(posedge clk);
    #1;
    model_latch();
    for (int k = 0; k < N; k++) check($sformatf("%s_rgb%0d", tag, k), w_rgb[k], exp_rgb[k]);
    check($sformatf("%s_tail_len", tag), 24'(mon_q.size()), 24'(exp_q.size()));
    for (int j = 0; j < exp_q.size() && j < mon_q.size(); j++)
      check($sformatf("%s_tail%0d", tag, j), 24'(mon_q[j]), 24'(exp_q[j]));
  endtask

  initial begin
    for (int k = 0; k < N; k++) exp_rgb[k] = '0;

    // reset state
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) check($sformatf("reset_rgb%0d", k), w_rgb[k], 24'h0);
    check("reset_sdo", 24'(w_sdi[N]), 24'h0);
    check("reset_cko", 24'(w_cki[N]), 24'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // two words: first stays in LED0, second forwarded into LED1
    push_word(24'hFFFFFF, 24);
    push_word(24'hF0F0F0, 24);
    send_frame(1'b0);
    latch_and_check("ff_f0");

    push_word(24'hF0F0F0, 24);
    push_word(24'hFFFFFF, 24);
    send_frame(1'b0);
    latch_and_check("f0_ff");

    // latch, then latch again with no new bits
    push_word(24'hAAAAAA, 24);
    push_word(24'h555555, 24);
    send_frame(1'b0);
    latch_and_check("aa_55");
    latch_and_check("relatch");

    // partial frame is discarded, then a full one loads
    push_word(24'h000ABC, 12);
    send_frame(1'b0);
    latch_and_check("partial");
    push_word(24'h123456, 24);
    send_frame(1'b0);
    latch_and_check("full");

    // six words through five devices: sixth exits the chain
    for (int i = 0; i < 6; i++) push_word(24'hFFF000, 24);
    send_frame(1'b0);
    latch_and_check("chain6");

    // reset mid-frame
    for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    cki_in = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    frame_q.delete();
    for (int k = 0; k < N; k++) exp_rgb[k] = '0;
    for (int k = 0; k < N; k++) check($sformatf("midrst_rgb%0d", k), w_rgb[k], 24'h0);
    check("midrst_sdo0", 24'(w_sdi[1]), 24'h0);
    check("midrst_cko0", 24'(w_cki[1]), 24'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_word(24'h00FF00, 24);
    send_frame(1'b0);
    latch_and_check("after_rst");

    // random frames of random length with random CKI timing
    for (int r = 0; r < 5; r++) begin
      int nb;
      nb = $urandom_range(0, 150);
      for (int i = 0; i < nb; i++) frame_q.push_back(1'($urandom_range(0, 1)));
      send_frame(1'b1);
      latch_and_check($sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
